// File: rtl/motion_updater_pkg.sv
// Shared encodings and defaults for the motion updater.
//   - direction encodings: DIR_INC / DIR_DEC
//   - axis mode encodings: MODE_WRAP / MODE_BOUNCE
//   - default VGA screen extents
package motion_updater_pkg;

  localparam logic DIR_INC     = 1'b0;
  localparam logic DIR_DEC     = 1'b1;

  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  localparam int VGA_H_RES = 640;
  localparam int VGA_V_RES = 480;

endpackage

// File: rtl/axis_step.sv
// Combinational single-axis position step.
// Takes the current position, step magnitude, direction and mode and
// produces the next position, the next direction and a bounce-clamp flag.
//   pos       in  W  current position
//   step      in  W  unsigned step magnitude
//   dir       in  1  current direction (DIR_INC / DIR_DEC)
//   mode      in  1  MODE_WRAP / MODE_BOUNCE
//   next_pos  out W  position after this step
//   next_dir  out 1  direction after this step
//   hit       out 1  bounce clamp happened on this step
module axis_step
  import motion_updater_pkg::*;
#(
  parameter int W   = 10,
  parameter int R   = 640,
  parameter int OBJ = 0
) (
  input  logic [W-1:0] pos,
  input  logic [W-1:0] step,
  input  logic         dir,
  input  logic         mode,
  output logic [W-1:0] next_pos,
  output logic         next_dir,
  output logic         hit
);

  localparam logic [W:0] R_V = (W+1)'(R);
  localparam logic [W:0] L_V = (W+1)'(R - 1 - OBJ);

  logic [W:0] p_ext;
  logic [W:0] s_ext;
  logic [W:0] s_mod;
  logic [W:0] sum;
  logic [W:0] res;

  assign p_ext = {1'b0, pos};
  assign s_ext = {1'b0, step};
  // Wrap mode must tolerate steps of a full screen or more.
  assign s_mod = s_ext % R_V;
  assign sum   = p_ext + s_ext;

  always_comb begin
    res      = p_ext;
    next_dir = dir;
    hit      = 1'b0;
    if (mode == MODE_WRAP) begin
      if (dir == DIR_INC) begin
        res = p_ext + s_mod;
        if (res >= R_V) res = res - R_V;
      end else begin
        if (s_mod > p_ext) res = p_ext + R_V - s_mod;
        else               res = p_ext - s_mod;
      end
    end else begin
      // A position already beyond the limit (e.g. left over from wrap mode)
      // is pulled back onto the limit as if it had just struck that edge.
      if (p_ext > L_V) begin
        res      = L_V;
        next_dir = DIR_DEC;
        hit      = 1'b1;
      end else if (dir == DIR_INC) begin
        if (sum > L_V) begin
          res      = L_V;
          next_dir = DIR_DEC;
          hit      = 1'b1;
        end else begin
          res = sum;
        end
      end else begin
        if (s_ext > p_ext) begin
          res      = '0;
          next_dir = DIR_INC;
          hit      = 1'b1;
        end else begin
          res = p_ext - s_ext;
        end
      end
    end
  end

  assign next_pos = res[W-1:0];

endmodule

// File: rtl/motion_updater.sv
// Object-position engine: every TICK_DIV enabled clocks advances (X, Y)
// by a per-axis step, each axis wrapping or bouncing at the screen edges.
//   clock      in  1  system clock
//   reset      in  1  asynchronous active-low reset
//   enable     in  1  tick counter runs only while high
//   load       in  1  synchronous load of position/direction
//   load_x/y   in  W  load coordinates
//   load_dx/dy in  1  load directions
//   step_x/y   in  W  step magnitudes, sampled at tick
//   bounce_x/y in  1  axis mode (0 wrap, 1 bounce)
//   pos_x/y    out W  current position
//   dir_x/y    out 1  current direction
//   hit_x/y    out 1  one-cycle pulse on a bounce clamp
//   update     out 1  one-cycle pulse after positions advanced
module motion_updater
  import motion_updater_pkg::*;
#(
  parameter int W        = 10,
  parameter int H_RES    = VGA_H_RES,
  parameter int V_RES    = VGA_V_RES,
  parameter int OBJ_W    = 0,
  parameter int OBJ_H    = 0,
  parameter int TICK_DIV = 25_000_000,
  parameter int INIT_X   = 0,
  parameter int INIT_Y   = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] load_x,
  input  logic [W-1:0] load_y,
  input  logic         load_dx,
  input  logic         load_dy,
  input  logic [W-1:0] step_x,
  input  logic [W-1:0] step_y,
  input  logic         bounce_x,
  input  logic         bounce_y,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y,
  output logic         dir_x,
  output logic         dir_y,
  output logic         hit_x,
  output logic         hit_y,
  output logic         update
);

  // TICK_DIV = 1 still needs a 1-bit counter to keep the compare legal.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;
  logic          tick;

  logic [W-1:0] nx_x;
  logic [W-1:0] nx_y;
  logic         nd_x;
  logic         nd_y;
  logic         nh_x;
  logic         nh_y;

  assign tick = (count == CNT_LAST) && enable;

  axis_step #(.W(W), .R(H_RES), .OBJ(OBJ_W)) u_axis_x (
    .pos      (pos_x),
    .step     (step_x),
    .dir      (dir_x),
    .mode     (bounce_x),
    .next_pos (nx_x),
    .next_dir (nd_x),
    .hit      (nh_x)
  );

  axis_step #(.W(W), .R(V_RES), .OBJ(OBJ_H)) u_axis_y (
    .pos      (pos_y),
    .step     (step_y),
    .dir      (dir_y),
    .mode     (bounce_y),
    .next_pos (nx_y),
    .next_dir (nd_y),
    .hit      (nh_y)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos_x  <= W'(INIT_X);
      pos_y  <= W'(INIT_Y);
      dir_x  <= DIR_INC;
      dir_y  <= DIR_INC;
      hit_x  <= 1'b0;
      hit_y  <= 1'b0;
      update <= 1'b0;
    end else if (load) begin
      pos_x  <= load_x;
      pos_y  <= load_y;
      dir_x  <= load_dx;
      dir_y  <= load_dy;
      hit_x  <= 1'b0;
      hit_y  <= 1'b0;
      update <= 1'b0;
    end else if (tick) begin
      pos_x  <= nx_x;
      pos_y  <= nx_y;
      dir_x  <= nd_x;
      dir_y  <= nd_y;
      hit_x  <= nh_x;
      hit_y  <= nh_y;
      update <= 1'b1;
    end else begin
      hit_x  <= 1'b0;
      hit_y  <= 1'b0;
      update <= 1'b0;
    end
  end

endmodule

// File: tb/tb_motion_updater.sv
// Directed testbench for motion_updater (TICK_DIV=4, OBJ_W=20, 640x480).
module tb_motion_updater;

  localparam int W = 10;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         load;
  logic [W-1:0] load_x, load_y;
  logic         load_dx, load_dy;
  logic [W-1:0] step_x, step_y;
  logic         bounce_x, bounce_y;
  logic [W-1:0] pos_x, pos_y;
  logic         dir_x, dir_y;
  logic         hit_x, hit_y;
  logic         update;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  motion_updater #(
    .W(W), .H_RES(640), .V_RES(480), .OBJ_W(20), .OBJ_H(0),
    .TICK_DIV(4), .INIT_X(0), .INIT_Y(0)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .load_x   (load_x),
    .load_y   (load_y),
    .load_dx  (load_dx),
    .load_dy  (load_dy),
    .step_x   (step_x),
    .step_y   (step_y),
    .bounce_x (bounce_x),
    .bounce_y (bounce_y),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .dir_x    (dir_x),
    .dir_y    (dir_y),
    .hit_x    (hit_x),
    .hit_y    (hit_y),
    .update   (update)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_update(input string tag, input int max_cyc, output int cycles);
    logic got;
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < max_cyc) begin
      clk_step();
      cycles++;
      got = update;
    end
    check({tag, "_seen"}, 32'(got), 32'd1);
  endtask

  task automatic do_load(input int x, input int y, input logic dx, input logic dy);
    load_x  = W'(x);
    load_y  = W'(y);
    load_dx = dx;
    load_dy = dy;
    load    = 1'b1;
    clk_step();
    load    = 1'b0;
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(pos_x), 32'(x));
    check({tag, "_y"}, 32'(pos_y), 32'(y));
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b0;
    load     = 1'b0;
    load_x   = '0;
    load_y   = '0;
    load_dx  = 1'b0;
    load_dy  = 1'b0;
    step_x   = W'(100);
    step_y   = W'(40);
    bounce_x = 1'b0;
    bounce_y = 1'b0;

    // Reset state
    #3;
    check_pos("rst_pos", 0, 0);
    check("rst_dir_x", 32'(dir_x), 0);
    check("rst_update", 32'(update), 0);
    check("rst_hit_x", 32'(hit_x), 0);
    #9;
    reset  = 1'b1;
    enable = 1'b1;

    // First tick after 4 enabled cycles
    wait_update("first", 20, cyc);
    check("first_latency", 32'(cyc), 32'd4);
    check_pos("first_pos", 100, 40);
    clk_step();
    check("first_pulse_len", 32'(update), 0);

    // Ticks 2..6, then 7th wraps X
    for (int i = 2; i <= 6; i++) wait_update("run", 20, cyc);
    check_pos("tick6", 600, 240);
    wait_update("tick7", 20, cyc);
    check_pos("tick7", 60, 280);

    // Decreasing wrap underflow
    do_load(30, 10, 1'b1, 1'b1);
    wait_update("decwrap", 20, cyc);
    check("decwrap_latency", 32'(cyc), 32'd4);
    check_pos("decwrap", 570, 450);
    check("decwrap_dir_x", 32'(dir_x), 1);

    // Bounce right edge, L = 619
    bounce_x = 1'b1;
    step_x   = W'(30);
    do_load(600, 0, 1'b0, 1'b0);
    wait_update("bounce", 20, cyc);
    check("bounce_x", 32'(pos_x), 619);
    check("bounce_dir", 32'(dir_x), 1);
    check("bounce_hit", 32'(hit_x), 1);
    check("bounce_hit_y", 32'(hit_y), 0);
    clk_step();
    check("bounce_hit_len", 32'(hit_x), 0);
    wait_update("bounce2", 20, cyc);
    check("bounce2_x", 32'(pos_x), 589);
    check("bounce2_hit", 32'(hit_x), 0);
    check("bounce2_dir", 32'(dir_x), 1);

    // Exact landing on L: no flip, no hit; next tick clamps
    do_load(589, 0, 1'b0, 1'b0);
    wait_update("exact", 20, cyc);
    check("exact_x", 32'(pos_x), 619);
    check("exact_dir", 32'(dir_x), 0);
    check("exact_hit", 32'(hit_x), 0);
    wait_update("exact2", 20, cyc);
    check("exact2_x", 32'(pos_x), 619);
    check("exact2_dir", 32'(dir_x), 1);
    check("exact2_hit", 32'(hit_x), 1);

    // Bounce off zero while decreasing
    do_load(10, 0, 1'b1, 1'b0);
    wait_update("zero", 20, cyc);
    check("zero_x", 32'(pos_x), 0);
    check("zero_dir", 32'(dir_x), 0);
    check("zero_hit", 32'(hit_x), 1);

    // Load coincident with tick
    bounce_x = 1'b0;
    step_x   = W'(100);
    do_load(0, 0, 1'b0, 1'b0);
    clk_step();
    clk_step();
    clk_step();
    load_x  = W'(5);
    load_y  = W'(5);
    load_dx = 1'b0;
    load_dy = 1'b0;
    load    = 1'b1;
    clk_step();
    load    = 1'b0;
    check_pos("ldtick", 5, 5);
    check("ldtick_update", 32'(update), 0);
    wait_update("ldtick_next", 20, cyc);
    check("ldtick_latency", 32'(cyc), 32'd4);
    check_pos("ldtick_next", 105, 45);

    // Enable gating for 10 cycles mid-count
    clk_step();
    clk_step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk_step();
      check("gated_no_update", 32'(update), 0);
    end
    enable = 1'b1;
    wait_update("gated", 20, cyc);
    check("gated_latency", 32'(cyc + 12), 32'd14);
    check_pos("gated", 205, 85);

    // Zero step still pulses update
    step_x = '0;
    step_y = '0;
    wait_update("zstep", 20, cyc);
    check_pos("zstep", 205, 85);

    // Async reset mid-run
    step_x = W'(100);
    step_y = W'(40);
    do_load(300, 200, 1'b1, 1'b0);
    clk_step();
    #2;
    reset = 1'b0;
    #1;
    check_pos("async_rst", 0, 0);
    check("async_rst_dir_x", 32'(dir_x), 0);
    check("async_rst_update", 32'(update), 0);
    #1;
    reset = 1'b1;
    wait_update("post_rst", 20, cyc);
    check("post_rst_latency", 32'(cyc), 32'd4);
    check_pos("post_rst", 100, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/motion_updater.md
# motion_updater

Parametrised object-position engine for the VGA display path. Every `TICK_DIV` clocks it advances an (X, Y) screen coordinate by a per-axis step and direction. Each axis either wraps modulo the screen size or bounces off the screen edges, clamping and reversing direction. It drives the digit/sprite origin consumed by the VGA 7-segment renderer and the Pong ball/paddle logic, and replaces the fixed-step, wrap-only position updater.

## Interface
Parameters:
- `W`, 10: coordinate width in bits.
- `H_RES`, 640: horizontal extent; X range 0..H_RES-1.
- `V_RES`, 480: vertical extent; Y range 0..V_RES-1.
- `OBJ_W`, 0: object width; bounce limit on X is H_RES-1-OBJ_W.
- `OBJ_H`, 0: object height; bounce limit on Y is V_RES-1-OBJ_H.
- `TICK_DIV`, 25_000_000: clocks per position update; must be ≥ 1.
- `INIT_X`, 0: X value after reset.
- `INIT_Y`, 0: Y value after reset.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  while 0, the tick counter holds and no updates occur.
- `load`  in  1  synchronous load of `load_x`/`load_y`/`load_dx`/`load_dy`.
- `load_x`, `load_y`  in  W  load coordinates; must be in range.
- `load_dx`, `load_dy`  in  1  load directions; 0 = increasing, 1 = decreasing.
- `step_x`, `step_y`  in  W  unsigned step magnitude, sampled at tick.
- `bounce_x`, `bounce_y`  in  1  axis mode; 0 = wrap, 1 = bounce.
- `pos_x`, `pos_y`  out  W  current position (registered).
- `dir_x`, `dir_y`  out  1  current direction (registered).
- `hit_x`, `hit_y`  out  1  one-cycle pulse when a bounce clamp occurred on that axis.
- `update`  out  1  one-cycle pulse when positions were advanced.

## Operation
- Tick counter runs 0..TICK_DIV-1 while `enable`=1; `tick` = (count==TICK_DIV-1) && enable. At TICK_DIV=1, tick is high every enabled cycle.
- Priority per edge: reset > load > tick > hold.
- `load`:
  - Positions and directions take the load values.
  - Tick counter clears to 0.
  - `update`, `hit_*` = 0.
- Wrap axis (mode = 0), computed in W+1 bits, with R = H_RES or V_RES:
  - Increasing: next = p+s, minus R if ≥ R.
  - Decreasing: next = p-s, plus R if negative.
  - Step s ≥ R is reduced modulo R first.
  - Direction is unchanged; `hit` = 0.
- Bounce axis (mode = 1), limit L = R-1-OBJ:
  - Increasing and p+s > L: next = L, dir flips to 1, `hit` = 1.
  - Decreasing and s > p: next = 0, dir flips to 0, `hit` = 1.
  - Otherwise: plain add/subtract, dir unchanged.
  - Landing exactly on L or 0 does not flip the direction and does not pulse `hit`.
- Out-of-range position entering bounce mode: the position is clamped to the limit on the next tick, and `hit` pulses.
- `step` = 0: position unchanged; `update` still pulses.
- Mode changes take effect at the next tick only.

## Timing
- Reset (async assert, sync release by the system):
  - `pos_x`=INIT_X, `pos_y`=INIT_Y.
  - `dir_*`=0, `hit_*`=0, `update`=0.
  - Counter = 0.
- First tick comes TICK_DIV enabled cycles after reset release or after `load`.
- Latency: 1 clock. The values sampled on the tick edge appear on `pos_*`/`dir_*` after that edge. `update` and `hit_*` are high for exactly that following cycle.
- Dropping `enable` freezes the counter mid-count; it resumes from the same count.
- `load` coincident with tick: load wins, no update pulse.
- Reset mid-count: the counter and all outputs return to their reset values immediately.

## Structure
- Shared package holds:
  - direction encodings `DIR_INC`=0 and `DIR_DEC`=1;
  - mode encodings `MODE_WRAP`=0 and `MODE_BOUNCE`=1;
  - default VGA constants 640/480.
- Sub-module `axis_step`:
  - Parameters W, R, OBJ.
  - Purely combinational: next position, next direction, hit.
  - Instantiated twice, for X and Y.
- Tick counter and output registers live in the top module. The counter width is $clog2(TICK_DIV).

## Test plan
- Reset and first tick, TICK_DIV=4, INIT=(0,0), step=(100,40), wrap: after 4 enabled cycles pos=(100,40) with `update`=1 for one cycle. After 6 ticks pos=(600,240); after the 7th, pos=(60,280).
- Decreasing wrap underflow: load (30,10), dir=(1,1), step=(100,40) → next tick pos=(570,450).
- Bounce right edge, OBJ_W=20 (L=619): load x=600, dir 0, step 30 → x=619, dir_x=1, `hit_x`=1 for one cycle. Next tick x=589, `hit_x`=0.
- Bounce exact landing: load x=589, step 30 → x=619, dir_x stays 0, no `hit_x`. Next tick clamps to 619, dir flips, `hit_x`=1.
- Load coincident with tick, and enable gating:
  - load (5,5) on the tick cycle → pos=(5,5), `update`=0, next update 4 cycles later.
  - `enable` low for 10 cycles mid-count → the update is delayed by exactly 10 cycles.
- Async reset mid-run: assert `reset`=0 between edges → outputs return to INIT/0 without a clock. After release, the first update comes after TICK_DIV cycles.
